// File: rtl/fft_pkg.sv
// Shared definitions for the FFT datapath: frame ordering modes and the
// index bit-reversal helper used by the reorder buffers.
package fft_pkg;

    // Per-frame output ordering, captured on the first sample of a frame.
    typedef enum logic {
        MODE_BITREV  = 1'b0,
        MODE_NATURAL = 1'b1
    } mode_e;

    // Widest index the helper can reverse; callers pass their own width r.
    localparam int MAX_R = 32;

    // Reverse the low r bits of x (bit k moves to bit r-1-k); upper bits are 0.
    function automatic logic [MAX_R-1:0] bitrev(input logic [MAX_R-1:0] x, input int r);
        logic [MAX_R-1:0] y;
        y = '0;
        for (int k = 0; k < MAX_R; k++) begin
            if (k < r) begin
                y[r-1-k] = x[k];
            end
        end
        return y;
    endfunction

endpackage

// File: rtl/reorder_bank.sv
// One frame of sample storage: N x W registers, synchronous write port and
// asynchronous read port so the read side sees data in the addressing cycle.
module reorder_bank #(
    parameter int R = 5,
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         we,
    input  logic [R-1:0] wr_addr,
    input  logic [W-1:0] wr_data,
    input  logic [R-1:0] rd_addr,
    output logic [W-1:0] rd_data
);

    localparam int N = 1 << R;

    logic [W-1:0] mem [N];

    // Store the incoming sample at its natural-order slot.
    // NOTE: the array is deliberately left out of reset; valid flags in the
    // control logic decide what is readable, so clearing storage buys nothing.
    // NOTE: state is updated with <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/bit_reverse_reorder.sv
// Ping-pong reorder buffer: frames of 2^R samples arrive in natural order and
// leave bit-reversed (or unchanged when the frame was tagged natural).
module bit_reverse_reorder
    import fft_pkg::*;
#(
    parameter int R = 5,
    parameter int W = 32
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [W-1:0] i_data,
    input  logic         i_mode,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [W-1:0] o_data,
    output logic         o_last
);

    localparam logic [R-1:0] LAST_IDX = '1;

    logic [R-1:0] wc;
    logic [R-1:0] rc;
    logic         wb;
    logic         rb;
    logic [1:0]   full;
    logic [1:0]   mode_q;

    logic         accept;
    logic         xfer;
    logic [R-1:0] rev_addr;
    logic [R-1:0] rd_addr;
    logic [W-1:0] bank_rd [2];

    // Flow control comes from registered flags only, so no i_ready -> o_ready path.
    assign o_ready = ~full[wb];
    assign o_valid = full[rb];
    assign o_last  = o_valid & (rc == LAST_IDX);

    assign accept = i_valid & o_ready;
    assign xfer   = o_valid & i_ready;

    assign rev_addr = R'(bitrev(MAX_R'(rc), R));
    assign rd_addr  = (mode_q[rb] == MODE_NATURAL) ? rc : rev_addr;
    assign o_data   = bank_rd[rb];

    for (genvar b = 0; b < 2; b++) begin : g_bank
        reorder_bank #(
            .R (R),
            .W (W)
        ) u_bank (
            .clk     (i_clk),
            .we      (accept & (wb == 1'(b))),
            .wr_addr (wc),
            .wr_data (i_data),
            .rd_addr (rd_addr),
            .rd_data (bank_rd[b])
        );
    end

    // Write/read counters, bank pointers and per-bank full/mode flags.
    // A completing write and a completing read always target different banks
    // (one needs the bank empty, the other full), so both flag updates coexist.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wc     <= '0;
            rc     <= '0;
            wb     <= 1'b0;
            rb     <= 1'b0;
            full   <= '0;
            mode_q <= '0;
        end else begin
            if (accept) begin
                wc <= wc + 1'b1;
                if (wc == '0) begin
                    mode_q[wb] <= i_mode;
                end
                if (wc == LAST_IDX) begin
                    full[wb] <= 1'b1;
                    wb       <= ~wb;
                end
            end
            if (xfer) begin
                rc <= rc + 1'b1;
                if (rc == LAST_IDX) begin
                    full[rb] <= 1'b0;
                    rb       <= ~rb;
                end
            end
        end
    end

endmodule

// File: tb/tb_bit_reverse_reorder.sv
// Scoreboard bench for bit_reverse_reorder (R=3, W=8): stimulus pushes the
// expected output stream, a negedge monitor pops and compares on transfers.
module tb_bit_reverse_reorder;

    localparam int R = 3;
    localparam int W = 8;
    localparam int N = 8;

    typedef struct {
        logic [W-1:0] data;
        logic         last;
    } exp_t;
    typedef logic [W-1:0] frame_t [N];

    logic         i_clk = 1'b0;
    logic         i_rst = 1'b1;
    logic         i_valid = 1'b0;
    logic         o_ready;
    logic [W-1:0] i_data = '0;
    logic         i_mode = 1'b0;
    logic         o_valid;
    logic         i_ready = 1'b0;
    logic [W-1:0] o_data;
    logic         o_last;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   xfer_count = 0;
    exp_t exp_q[$];
    exp_t mon_e;

    // Reference model state for model-driven tests.
    bit           use_model = 1'b0;
    bit           rand_ready = 1'b0;
    logic [W-1:0] mbuf [N];
    logic         mmode;
    int           widx = 0;

    bit_reverse_reorder #(.R(R), .W(W)) dut (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_data  (i_data),
        .i_mode  (i_mode),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_data  (o_data),
        .o_last  (o_last)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int rev3(input int i);
        return {29'd0, i[0], i[1], i[2]};
    endfunction

    task automatic expect_list(input frame_t v);
        exp_t e;
        for (int k = 0; k < N; k++) begin
            e.data = v[k];
            e.last = (k == N - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic model_accept(input logic [W-1:0] d, input logic m);
        exp_t e;
        if (widx == 0) mmode = m;
        mbuf[widx] = d;
        widx++;
        if (widx == N) begin
            widx = 0;
            if (use_model) begin
                for (int k = 0; k < N; k++) begin
                    e.data = mmode ? mbuf[k] : mbuf[rev3(k)];
                    e.last = (k == N - 1);
                    exp_q.push_back(e);
                end
            end
        end
    endtask

    // Present one sample and hold it until accepted (bounded wait).
    task automatic push(input logic [W-1:0] d, input logic m);
        bit acc;
        bit done;
        done = 1'b0;
        i_valid = 1'b1;
        i_data  = d;
        i_mode  = m;
        for (int t = 0; t < 2000; t++) begin
            @(negedge i_clk);
            acc = o_ready;
            @(posedge i_clk);
            #1;
            if (acc) begin
                done = 1'b1;
                break;
            end
        end
        i_valid = 1'b0;
        if (done) model_accept(d, m);
        else begin
            n_cmp++;
            n_bad++;
            $display("FAIL push_timeout: sample 0x%0h not accepted, expected acceptance", d);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 500) begin
            @(posedge i_clk);
            #1;
            t++;
        end
        check("drain_remaining", exp_q.size(), 0);
    endtask

    // Monitor: every output transfer must match the head of the scoreboard.
    always @(negedge i_clk) begin
        if (!i_rst && o_valid && i_ready) begin
            xfer_count++;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_output: got data 0x%0h last %0b, expected no output", o_data, o_last);
            end else begin
                mon_e = exp_q.pop_front();
                check("out_last_data", {23'd0, o_last, o_data}, {23'd0, mon_e.last, mon_e.data});
            end
        end
    end

    // Random downstream back-pressure when enabled.
    initial begin
        forever begin
            @(posedge i_clk);
            #1;
            if (rand_ready) i_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time exhausted, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit got;
        bit lx;
        bit rdy;
        int x0;

        // Reset state
        idle(2);
        i_rst = 1'b0;
        check("reset_o_valid", o_valid, 0);
        check("reset_o_ready", o_ready, 1);
        check("reset_o_last", o_last, 0);

        // Bit-reverse frame, latency of first output
        i_ready = 1'b1;
        expect_list('{8'd0, 8'd4, 8'd2, 8'd6, 8'd1, 8'd5, 8'd3, 8'd7});
        for (int i = 0; i < N; i++) begin
            if (i == N - 1) check("valid_before_last_accept", o_valid, 0);
            push(8'(i), 1'b0);
        end
        check("valid_after_last_accept", o_valid, 1);
        check("last_low_on_first", o_last, 0);
        wait_drain();

        // Natural-order frame
        expect_list('{8'd8, 8'd9, 8'd10, 8'd11, 8'd12, 8'd13, 8'd14, 8'd15});
        for (int i = 0; i < N; i++) push(8'(8 + i), 1'b1);
        wait_drain();

        // Back-to-back frames with differing modes; mid-frame mode flips ignored
        expect_list('{8'd16, 8'd20, 8'd18, 8'd22, 8'd17, 8'd21, 8'd19, 8'd23});
        expect_list('{8'd24, 8'd25, 8'd26, 8'd27, 8'd28, 8'd29, 8'd30, 8'd31});
        for (int i = 0; i < N; i++) push(8'(16 + i), (i == 0) ? 1'b0 : 1'b1);
        for (int i = 0; i < N; i++) push(8'(24 + i), (i == 0) ? 1'b1 : 1'b0);
        wait_drain();

        // Both banks fill under back-pressure, then drain in order
        i_ready = 1'b0;
        expect_list('{8'd40, 8'd44, 8'd42, 8'd46, 8'd41, 8'd45, 8'd43, 8'd47});
        expect_list('{8'd48, 8'd52, 8'd50, 8'd54, 8'd49, 8'd53, 8'd51, 8'd55});
        expect_list('{8'd56, 8'd60, 8'd58, 8'd62, 8'd57, 8'd61, 8'd59, 8'd63});
        for (int i = 0; i < 2 * N; i++) push(8'(40 + i), 1'b0);
        check("ready_low_both_full", o_ready, 0);
        i_valid = 1'b1;
        i_data  = 8'd56;
        i_mode  = 1'b0;
        for (int t = 0; t < N; t++) begin
            @(negedge i_clk);
            check("stall_ready_low", o_ready, 0);
            @(posedge i_clk);
            #1;
        end
        i_ready = 1'b1;
        got = 1'b0;
        for (int t = 0; t < 40; t++) begin
            @(negedge i_clk);
            lx  = o_valid & i_ready & o_last;
            rdy = o_ready;
            @(posedge i_clk);
            #1;
            if (lx) begin
                check("ready_after_first_last", o_ready, 1);
                got = 1'b1;
                break;
            end
            check("ready_low_while_draining", rdy, 0);
        end
        check("first_frame_last_seen", got, 1);
        for (int i = 0; i < N; i++) push(8'(56 + i), 1'b0);
        wait_drain();

        // Continuous streaming of four frames, gap-free output
        use_model = 1'b1;
        x0 = xfer_count;
        for (int i = 0; i < 4 * N; i++) push(8'(i), 1'b0);
        check("stream_xfers_during_input", xfer_count - x0, 3 * N);
        idle(N);
        check("stream_xfers_total", xfer_count - x0, 4 * N);
        wait_drain();

        // Random valid/ready toggling over 50 frames
        rand_ready = 1'b1;
        for (int f = 0; f < 50; f++) begin
            for (int i = 0; i < N; i++) begin
                idle($urandom_range(0, 2));
                push(8'($urandom), 1'($urandom));
            end
        end
        rand_ready = 1'b0;
        idle(1);
        i_ready = 1'b1;
        wait_drain();
        use_model = 1'b0;

        // Reset mid-frame while the other bank is being read
        i_ready = 1'b0;
        expect_list('{8'd64, 8'd68, 8'd66, 8'd70, 8'd65, 8'd69, 8'd67, 8'd71});
        for (int i = 0; i < N; i++) push(8'(64 + i), 1'b0);
        i_ready = 1'b1;
        for (int i = 0; i < 5; i++) push(8'(72 + i), 1'b0);
        check("pre_reset_remaining", exp_q.size(), 3);
        i_rst = 1'b1;
        exp_q.delete();
        widx = 0;
        idle(1);
        i_rst = 1'b0;
        check("post_reset_o_valid", o_valid, 0);
        check("post_reset_o_ready", o_ready, 1);
        check("post_reset_o_last", o_last, 0);
        expect_list('{8'd0, 8'd4, 8'd2, 8'd6, 8'd1, 8'd5, 8'd3, 8'd7});
        for (int i = 0; i < N; i++) push(8'(i), 1'b0);
        wait_drain();
        idle(2);
        check("final_o_valid", o_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bit_reverse_reorder.md
Name: bit_reverse_reorder

Overview:
- Streaming reorder buffer for the in-place FFT datapath: accepts frames of 2^R samples in natural order and emits each frame in bit-reversed order, or in natural order when bypassed.
- Ping-pong double buffer, so one frame is written while the previous one is read; sustains 1 sample/cycle.
- Parametrised successor of the combinational address bit-reverser: adds data storage, flow control, per-frame mode and frame delimiting.
- Sits between the FFT butterfly core output and the downstream consumer; a mirrored instance can sit at the FFT input.

Parameters:
- R, 5, log2 of frame length; N = 2^R samples per frame, R >= 1.
- W, 32, sample width in bits (e.g. packed {re, im}).

Ports:
- i_clk  input  1  clock; all logic is on the rising edge.
- i_rst  input  1  reset; synchronous, active-high.
- i_valid  input  1  input sample valid.
- o_ready  output  1  block can accept an input sample.
- i_data  input  W  input sample.
- i_mode  input  1  0 = bit-reverse, 1 = natural-order bypass; sampled on the first accepted sample of each frame.
- o_valid  output  1  output sample valid.
- i_ready  input  1  downstream accepts the output sample.
- o_data  output  W  output sample.
- o_last  output  1  high with the final sample (index N-1) of each output frame.

Behaviour:
- Handshakes: input accepted when i_valid & o_ready; output transfers when o_valid & i_ready. o_valid and o_data hold steady until the transfer.
- Storage: two banks, each N x W, plus a per-bank FULL flag and a per-bank stored mode bit.
- Write side:
  - Write counter wc (R bits) and write-bank pointer wb (1 bit).
  - On accept, i_data is written to bank[wb][wc] and wc increments.
  - When wc == 0, i_mode is captured into mode[wb].
  - On the accept at wc == N-1, wc wraps to 0, FULL[wb] is set and wb toggles.
- o_ready = !FULL[wb]. It depends on registered state only; there is no combinational path from i_ready.
- Read side:
  - Read counter rc (R bits) and read-bank pointer rb (1 bit).
  - o_valid = FULL[rb].
  - Read address is bitrev(rc) when mode[rb] = 0, else rc. bitrev maps bit k to bit R-1-k.
  - o_data is the asynchronous read of bank[rb] at that address.
  - o_last = o_valid & (rc == N-1).
  - On transfer, rc increments. On the transfer at rc == N-1, rc wraps to 0, FULL[rb] clears and rb toggles.
- Latency: the first output sample of a frame is valid in the cycle after that frame's last input is accepted. With i_ready held high and continuous input, output is gap-free at 1 sample/cycle.
- Simultaneous events:
  - Completing a write into one bank and completing a read of the other bank in the same cycle: both flags update that cycle, with no loss.
  - A bank freed by a read becomes writable the following cycle, because o_ready is registered-state based.
- Both banks full: o_ready = 0 until the read side finishes a bank. Input is stalled; data is never overwritten.
- Reset (any time, including mid-frame):
  - wc, rc, wb, rb, FULL[*] and mode[*] clear to 0.
  - Outputs after reset: o_valid = 0, o_last = 0, o_ready = 1.
  - Partial frames are discarded. Bank contents are not cleared and o_data is don't-care while o_valid = 0.
- i_mode changes mid-frame have no effect until the next frame start.
- o_data while o_valid = 0 is unspecified; the bench must not check it.

Decomposition:
- Package fft_pkg: bitrev function parametrised by R, and the mode constants MODE_BITREV = 1'b0, MODE_NATURAL = 1'b1.
- One natural sub-module, reorder_bank: a single N x W register array with one synchronous write port and one asynchronous read port. It is instantiated twice.
- Control (counters, flags, pointers) stays in the top-level module.

Test Plan:
- R=3, W=8, i_ready=1, mode 0, inputs 0..7 back-to-back -> outputs 0,4,2,6,1,5,3,7; o_valid rises the cycle after input 7 is accepted; o_last only with 7.
- Same stimulus with mode 1 -> outputs 0..7 in order. Frame A mode 0 then frame B mode 1 back-to-back -> each frame uses its own captured mode.
- i_ready=0 while pushing 24 samples continuously -> exactly 16 accepted, o_ready low from the 17th cycle; raising i_ready drains frame 1 and then frame 2 in order; o_ready returns 1 the cycle after frame 1's o_last transfer.
- Continuous input and i_ready=1 for 4 frames of values 0..31 -> output gap-free after the first 8-cycle fill; each frame is bit-reversed within its own 8-sample window.
- Random i_valid/i_ready toggling over 50 frames -> output sequence matches the scoreboard model exactly; no drops or duplicates.
- Assert i_rst for 1 cycle after 5 samples of a frame, with the other bank full and mid-read -> next cycle o_valid=0, o_ready=1; a fresh frame 0..7 then produces 0,4,2,6,1,5,3,7.
